mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single memory controller (byte-serial RAM port) between instruction fetch (IF) and the load/store
//   executor (LS). Latches one-cycle request pulses, grants one requester at a time, and forwards the controller's
//   ok/data back to the granted requester. Sits between the IF unit / LS executor and the memory controller.
//   Drops squashed IF requests and LS loads on rollback; never drops stores.
// PARAMETERS
//   ADDR_W  32  address width (matches `ADDR_TYPE)
//   DATA_W  32  data width (matches `DATA_TYPE)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous, active-high reset
//   rdy            in   1       global ready; low = hold every register
//   if_ena         in   1       IF request pulse (read, size 4)
//   if_addr        in   ADDR_W  IF fetch address
//   ls_ena         in   1       LS request pulse
//   ls_addr        in   ADDR_W  LS address
//   ls_data        in   DATA_W  LS store data
//   ls_wr_flag     in   1       `FLAG_READ / `FLAG_WRITE
//   ls_size        in   3       byte count: 1, 2 or 4
//   rollback_flag  in   1       ROB rollback pulse
//   ok_to_if       out  1       one-cycle IF completion pulse
//   data_to_if     out  DATA_W  fetched word, valid with ok_to_if
//   ok_to_ls       out  1       one-cycle LS completion pulse (loads and stores)
//   data_to_ls     out  DATA_W  load data, valid with ok_to_ls
//   ena_to_mc      out  1       one-cycle request pulse to memory controller
//   addr_to_mc     out  ADDR_W  request address
//   data_to_mc     out  DATA_W  store data
//   wr_flag_to_mc  out  1       read/write
//   size_to_mc     out  3       byte count
//   ok_flag_from_mc in  1       controller completion pulse
//   data_from_mc   in   DATA_W  controller read data
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; both pending slots empty; last_grant = LS.
//   rdy low: no register changes, no pulses issued.
//   Slots: if_ena / ls_ena captured into a pending slot at the sampling edge. One outstanding request per requester;
//     a pulse while that requester's slot is full or in flight is ignored (bench asserts it never happens).
//   States: IDLE, BUSY_IF, BUSY_LS, DRAIN.
//   IDLE: if any slot full (including one captured at this edge), pick winner, drive ena_to_mc=1 with its fields
//     for exactly one cycle, clear that slot, go BUSY_IF/BUSY_LS. Request pulse at edge N -> ena_to_mc high after edge N.
//   Priority: fixed LS over IF (LS holds ROB head work).
//   BUSY_x: on ok_flag_from_mc, pulse ok_to_x=1 for one cycle with data_to_x=data_from_mc, return to IDLE.
//     Next grant earliest the edge after the return (one idle bubble between transactions).
//   Rollback (edge where rollback_flag=1):
//     - IF slot cleared; pending LS slot cleared only if it is a read.
//     - BUSY_IF or BUSY_LS-read -> DRAIN (the controller transaction cannot be aborted).
//     - BUSY_LS-write continues normally; ok_to_ls still pulses.
//     - Requests arriving on the rollback edge are discarded.
//   DRAIN: wait for ok_flag_from_mc, swallow it (no ok_to_* pulse), go IDLE.
//   Simultaneous ok_flag and rollback in BUSY_x (read): completion swallowed, go IDLE directly.
//   ok_flag_from_mc in IDLE: ignored.
//   Async reset mid-transaction: everything cleared; memory controller is reset by the same rst.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin instead of fixed priority. When both slots are full, grant the requester
//     not in last_grant; last_grant updates on every grant. Undefined: fixed LS priority; last_grant unused.
// STRUCTURE
//   defines.v: `ADDR_TYPE, `DATA_TYPE, `FLAG_READ/`FLAG_WRITE, `TRUE/`FALSE, arbiter state encodings (2-bit STATUS).
//   One sub-module: mem_arb_slot, instantiated twice. Holds valid/addr/data/wr/size; ports: capture, clear, flush_reads.
// TESTING
//   1. IF pulse addr=0x100. mc ok after 4 cycles with data=0x00A00093.
//      -> ena_to_mc one cycle after the request, size 4, read; ok_to_if once with data 0x00A00093.
//   2. IF and LS (SW 0x1000, data 0xDEADBEEF) on the same edge. -> LS granted first (write, size 4); IF granted
//      one cycle after the LS ok. With MEM_ARB_RR_EN and last_grant=LS, IF is granted first.
//   3. LB 0x30004 in flight, rollback. -> state DRAIN; mc ok swallowed, no ok_to_ls; next pending IF granted afterwards.
//   4. SB 0x30000 in flight plus pending IF, rollback. -> store completes with ok_to_ls=1; IF slot cleared; no IF grant.
//   5. rdy held low 3 cycles mid BUSY_LS with ok_flag high. -> nothing changes; ok_to_ls pulses only after rdy rises.
//   6. Assert rst during BUSY_IF. -> all outputs 0 immediately; after release, a new LS request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encodings, read/write flags
// and the fixed instruction-fetch transfer size.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_LS = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;

    localparam logic [2:0] IF_FETCH_SIZE = 3'd4;

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request slot: holds a captured request until it is granted,
// cleared, or (for reads) flushed by a rollback.
import mem_arbiter_pkg::*;

module mem_arb_slot #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic              flush_reads,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wr,
    input  logic [2:0]        in_size,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              wr,
    output logic [2:0]        size
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            wr    <= FLAG_READ;
            size  <= '0;
        end else if (clear || (flush_reads && wr == FLAG_READ)) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            addr  <= in_addr;
            data  <= in_data;
            wr    <= in_wr;
            size  <= in_size;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory controller between instruction fetch and load/store.
// Optional MEM_ARB_RR_EN selects round-robin instead of fixed LS-over-IF priority.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_ena,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_ena,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_data,
    input  logic              ls_wr_flag,
    input  logic [2:0]        ls_size,
    input  logic              rollback_flag,
    output logic              ok_to_if,
    output logic [DATA_W-1:0] data_to_if,
    output logic              ok_to_ls,
    output logic [DATA_W-1:0] data_to_ls,
    output logic              ena_to_mc,
    output logic [ADDR_W-1:0] addr_to_mc,
    output logic [DATA_W-1:0] data_to_mc,
    output logic              wr_flag_to_mc,
    output logic [2:0]        size_to_mc,
    input  logic              ok_flag_from_mc,
    input  logic [DATA_W-1:0] data_from_mc
);

    logic [1:0]        state;
    logic              cur_wr;

    logic              if_valid, if_q_wr;
    logic [ADDR_W-1:0] if_q_addr;
    logic [DATA_W-1:0] if_q_data;
    logic [2:0]        if_q_size;
    logic              ls_valid, ls_q_wr;
    logic [ADDR_W-1:0] ls_q_addr;
    logic [DATA_W-1:0] ls_q_data;
    logic [2:0]        ls_q_size;

    logic              if_new, ls_new, if_req, ls_req;
    logic              grant_if, grant_ls, pick_ls;
    logic [ADDR_W-1:0] if_eff_addr, ls_eff_addr;
    logic [DATA_W-1:0] if_eff_data, ls_eff_data;
    logic              if_eff_wr, ls_eff_wr;
    logic [2:0]        if_eff_size, ls_eff_size;

    // A pulse is accepted only if that requester has nothing pending or in flight.
    assign if_new = if_ena && !rollback_flag && !if_valid && state != ST_BUSY_IF;
    assign ls_new = ls_ena && !rollback_flag && !ls_valid && state != ST_BUSY_LS;
    assign if_req = (if_valid && !rollback_flag) || if_new;
    assign ls_req = (ls_valid && !(rollback_flag && ls_q_wr == FLAG_READ)) || ls_new;

    assign if_eff_addr = if_valid ? if_q_addr : if_addr;
    assign if_eff_data = if_valid ? if_q_data : '0;
    assign if_eff_wr   = if_valid ? if_q_wr   : FLAG_READ;
    assign if_eff_size = if_valid ? if_q_size : IF_FETCH_SIZE;
    assign ls_eff_addr = ls_valid ? ls_q_addr : ls_addr;
    assign ls_eff_data = ls_valid ? ls_q_data : ls_data;
    assign ls_eff_wr   = ls_valid ? ls_q_wr   : ls_wr_flag;
    assign ls_eff_size = ls_valid ? ls_q_size : ls_size;

`ifdef MEM_ARB_RR_EN
    logic last_grant_ls;

    assign pick_ls = !last_grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_ls <= 1'b1;
        end else if (grant_if || grant_ls) begin
            last_grant_ls <= grant_ls;
        end
    end
`else
    assign pick_ls = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (rdy && state == ST_IDLE) begin
            grant_ls = ls_req && (!if_req || pick_ls);
            grant_if = if_req && !grant_ls;
        end
    end

    mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_slot (
        .clk         (clk),
        .rst         (rst),
        .capture     (rdy && if_new),
        .clear       (rdy && (grant_if || rollback_flag)),
        .flush_reads (1'b0),
        .in_addr     (if_addr),
        .in_data     ('0),
        .in_wr       (FLAG_READ),
        .in_size     (IF_FETCH_SIZE),
        .valid       (if_valid),
        .addr        (if_q_addr),
        .data        (if_q_data),
        .wr          (if_q_wr),
        .size        (if_q_size)
    );

    mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ls_slot (
        .clk         (clk),
        .rst         (rst),
        .capture     (rdy && ls_new),
        .clear       (rdy && grant_ls),
        .flush_reads (rdy && rollback_flag),
        .in_addr     (ls_addr),
        .in_data     (ls_data),
        .in_wr       (ls_wr_flag),
        .in_size     (ls_size),
        .valid       (ls_valid),
        .addr        (ls_q_addr),
        .data        (ls_q_data),
        .wr          (ls_q_wr),
        .size        (ls_q_size)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_wr        <= FLAG_READ;
            ok_to_if      <= 1'b0;
            data_to_if    <= '0;
            ok_to_ls      <= 1'b0;
            data_to_ls    <= '0;
            ena_to_mc     <= 1'b0;
            addr_to_mc    <= '0;
            data_to_mc    <= '0;
            wr_flag_to_mc <= FLAG_READ;
            size_to_mc    <= '0;
        end else begin
            // Pulses last one cycle; they are only ever raised on a ready edge.
            ena_to_mc <= 1'b0;
            ok_to_if  <= 1'b0;
            ok_to_ls  <= 1'b0;
            if (rdy) begin
                case (state)
                    ST_IDLE: begin
                        if (grant_if || grant_ls) begin
                            ena_to_mc     <= 1'b1;
                            addr_to_mc    <= grant_ls ? ls_eff_addr : if_eff_addr;
                            data_to_mc    <= grant_ls ? ls_eff_data : if_eff_data;
                            wr_flag_to_mc <= grant_ls ? ls_eff_wr   : if_eff_wr;
                            size_to_mc    <= grant_ls ? ls_eff_size : if_eff_size;
                            cur_wr        <= grant_ls ? ls_eff_wr   : if_eff_wr;
                            state         <= grant_ls ? ST_BUSY_LS  : ST_BUSY_IF;
                        end
                    end
                    ST_BUSY_IF: begin
                        if (rollback_flag) begin
                            state <= ok_flag_from_mc ? ST_IDLE : ST_DRAIN;
                        end else if (ok_flag_from_mc) begin
                            ok_to_if   <= 1'b1;
                            data_to_if <= data_from_mc;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_BUSY_LS: begin
                        // An in-flight store survives rollback; only loads are squashed.
                        if (rollback_flag && cur_wr == FLAG_READ) begin
                            state <= ok_flag_from_mc ? ST_IDLE : ST_DRAIN;
                        end else if (ok_flag_from_mc) begin
                            ok_to_ls   <= 1'b1;
                            data_to_ls <= data_from_mc;
                            state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (ok_flag_from_mc) begin
                            state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
